// File: rtl/branch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_unit
// Brief    : Fetch PC owner; resolves branches/jumps, redirects fetch and
//            squashes wrong-path IF/ID contents with a multi-cycle flush.
// Revision : 1.0 - initial release
// ============================================================================
module branch_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_cond,
  input  logic        br_uncond,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_offset,
  input  logic [31:0] jmp_target,
  output logic [31:0] pc,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] branch_count,
  output logic [31:0] taken_count
);

  localparam logic [2:0] c_flush_load = FLUSH_CYCLES[2:0];

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_flush_cnt;
  logic [2:0]  w_flush_cnt_nxt;
  logic        w_flush_nxt;
  logic        w_redirect_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_flush;
  logic        r_redirect;
  logic [31:0] r_branch_count;
  logic [31:0] r_taken_count;

  logic        w_taken;
  logic        w_accept;
  logic        w_redirect_now;
  logic [31:0] w_target;

  // Condition/offset/target only matter when br_valid qualifies them.
  assign w_taken        = br_valid & (br_uncond | br_cond);
  assign w_accept       = br_valid & (r_state == RUN);
  assign w_redirect_now = w_accept & w_taken;
  assign w_target       = br_uncond ? {jmp_target[31:2], 2'b00}
                                    : br_pc + 32'd4 + {br_offset[29:0], 2'b00};

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_flush_nxt     = 1'b0;
    w_redirect_nxt  = 1'b0;

    if (w_redirect_now) begin
      w_pc_nxt = w_target;
    end else if (stall) begin
      w_pc_nxt = r_pc;
    end else begin
      w_pc_nxt = r_pc + 32'd4;
    end

    case (r_state)
      RUN: begin
        if (w_redirect_now) begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = c_flush_load;
          w_flush_nxt     = 1'b1;
          w_redirect_nxt  = 1'b1;
        end
      end
      FLUSH: begin
        // Flush window counts down regardless of stall.
        if (r_flush_cnt <= 3'd1) begin
          w_state_nxt     = RUN;
          w_flush_cnt_nxt = 3'd0;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 3'd1;
          w_flush_nxt     = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = RUN;
        w_flush_cnt_nxt = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_flush_cnt    <= 3'd0;
      r_pc           <= RESET_PC;
      r_flush        <= 1'b0;
      r_redirect     <= 1'b0;
      r_branch_count <= 32'd0;
      r_taken_count  <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_pc        <= w_pc_nxt;
      r_flush     <= w_flush_nxt;
      r_redirect  <= w_redirect_nxt;
      if (w_accept) begin
        r_branch_count <= r_branch_count + 32'd1;
      end
      if (w_redirect_now) begin
        r_taken_count <= r_taken_count + 32'd1;
      end
    end
  end

  assign pc           = r_pc;
  assign flush        = r_flush;
  assign redirect     = r_redirect;
  assign branch_count = r_branch_count;
  assign taken_count  = r_taken_count;

endmodule
`default_nettype wire
